hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline hazard controller for the five-stage core. Sits beside the RAW forwarding unit and covers what forwarding cannot: load-use stalls, taken-branch flushes, and freezing the pipe while a multi-cycle data-memory access completes. It also bounds the memory wait with a timeout and keeps a saturating count of stall cycles for performance measurement.

## Interface
Parameters:
- WIDTH, 5, register-address width (matches the forwarding unit).
- MAX_WAIT, 16, maximum memory-wait cycles before error.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- RegS1D  in  WIDTH  source register 1 of the instruction in Decode.
- RegS2D  in  WIDTH  source register 2 of the instruction in Decode.
- RegDestE  in  WIDTH  destination register of the instruction in Execute.
- MemReadE  in  1  instruction in Execute is a load.
- BranchTakenE  in  1  branch/jump resolved taken in Execute.
- MemReqM  in  1  instruction in Memory accesses data memory.
- MemReadyM  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1 each  hold the PC, IF/ID, ID/EX and EX/MEM registers.
- FlushD, FlushE, FlushW  out  1 each  bubble into IF/ID, ID/EX and MEM/WB.
- MemErr  out  1  sticky memory-timeout error.
- StallCount  out  CNT_W  saturating count of cycles with StallF=1.

## Operation
FSM states:
- HZ_RUN — normal flow.
- HZ_WAIT — data-memory access outstanding.
- HZ_ERR — memory timeout; terminal until reset.

State transitions:
- HZ_RUN -> HZ_WAIT when MemReqM && !MemReadyM.
- HZ_WAIT -> HZ_RUN when MemReadyM.
- HZ_WAIT -> HZ_ERR when WaitCnt == MAX_WAIT-1 && !MemReadyM.
- HZ_ERR stays in HZ_ERR.

Load-use condition (LU):
- MemReadE && RegDestE != 0 && (RegDestE == RegS1D || RegDestE == RegS2D).
- Register 0 never causes a hazard.

Output rules are evaluated in priority order; the first match applies:
- **Memory stall.** Applies in HZ_RUN with MemReqM && !MemReadyM, or in HZ_WAIT with !MemReadyM. Drive StallF=StallD=StallE=StallM=1 and FlushW=1. FlushD=FlushE=0. Branch and LU are ignored and are re-evaluated once the pipe resumes.
- **HZ_ERR.** All four stalls are 1, FlushW=1, MemErr=1.
- **BranchTakenE.** FlushD=FlushE=1, no stalls. If LU is also true, the flush wins, because the Decode instruction is on the wrong path.
- **LU.** StallF=StallD=1, FlushE=1, for exactly one cycle. On the next cycle the load is in Memory and the forwarding unit covers the dependency.
- **Otherwise.** All outputs are 0.

WaitCnt (internal, width clog2(MAX_WAIT)+1):
- Cleared on entry to HZ_WAIT.
- Increments on each HZ_WAIT cycle without MemReadyM.
- Cleared on return to HZ_RUN.

StallCount:
- Increments on each cycle with StallF=1.
- Saturates at 2^CNT_W-1; never wraps.

## Timing
- All stall and flush outputs are Mealy: combinational from state and the current inputs, so they take effect in the same cycle. There is no registered latency.
- MemErr and StallCount are registered.
- While rst=1, every output is forced to 0.
- On the first edge with rst=1: state=HZ_RUN, WaitCnt=0, StallCount=0, MemErr=0.
- A reset during HZ_WAIT or HZ_ERR aborts the wait; the pipeline restarts from HZ_RUN.
- MemReadyM high in the same cycle as MemReqM in HZ_RUN is a zero-wait access: no stall and no state change.
- MemReadyM high in the last allowed wait cycle (WaitCnt == MAX_WAIT-1) returns to HZ_RUN, not HZ_ERR.
- A memory wait of N cycles (N < MAX_WAIT) asserts StallF for exactly N cycles.

## Structure
- Package hazard_pkg holds:
  - the typedef enum logic [1:0] hz_state_t {HZ_RUN, HZ_WAIT, HZ_ERR};
  - the default constants for WIDTH, MAX_WAIT and CNT_W.
- One combinational sub-module, load_use_detect, computes LU from RegS1D, RegS2D, RegDestE and MemReadE.
- The top level holds the FSM, WaitCnt, StallCount and the output priority logic.

## Test plan
- **Load-use.** MemReadE=1, RegDestE=5'b01001, RegS1D=5'b01001 -> one cycle of StallF=StallD=FlushE=1. The next cycle, with MemReadE=0, all outputs are 0.
- **Register 0.** MemReadE=1, RegDestE=0, RegS2D=0 -> no stall. BranchTakenE=1 together with a load-use match -> FlushD=FlushE=1, StallF=0.
- **Memory wait.** MemReqM=1, MemReadyM low for 3 cycles then high -> all stalls and FlushW=1 for 3 cycles, then 0. StallCount advances by 3. State is back in HZ_RUN.
- **Timeout.** MAX_WAIT=4 with MemReadyM never high -> MemErr=1 after 4 wait cycles. Stalls stay at 1 until rst. After rst: MemErr=0, StallCount=0.
- **Priority.** Memory stall together with BranchTakenE=1 -> FlushD=FlushE=0, all stalls 1. After MemReadyM, a still-asserted BranchTakenE flushes.
- **Saturation.** CNT_W=4 with 20 stalled cycles -> StallCount=15 and holds there.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared state encoding and default sizing for the hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_RUN  = 2'd0,
    HZ_WAIT = 2'd1,
    HZ_ERR  = 2'd2
  } hz_state_t;

  localparam int DEF_WIDTH    = 5;
  localparam int DEF_MAX_WAIT = 16;
  localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/hazard_stall_ctrl_load_use.sv
// rtl/hazard_stall_ctrl_load_use.sv - load-use hazard detector between Execute and Decode
module load_use_detect
  import hazard_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] RegS1D,
  input  logic [WIDTH-1:0] RegS2D,
  input  logic [WIDTH-1:0] RegDestE,
  input  logic             MemReadE,
  output logic             LoadUse
);

  // Register 0 is hard-wired, so a load targeting it can never create a dependency.
  assign LoadUse = MemReadE && (RegDestE != '0) &&
                   ((RegDestE == RegS1D) || (RegDestE == RegS2D));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - stall/flush control for load-use, taken branches and memory waits
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] RegS1D,
  input  logic [WIDTH-1:0] RegS2D,
  input  logic [WIDTH-1:0] RegDestE,
  input  logic             MemReadE,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount
);

  localparam int WC_W = $clog2(MAX_WAIT) + 1;
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MAX_WAIT - 1);

  hz_state_t        state, stateNext;
  logic [WC_W-1:0]  waitCnt, waitNext;
  logic [CNT_W-1:0] stallCnt;
  logic             memErrQ;
  logic             loadUse;
  logic             memStall;
  logic             stallFInt, stallDInt, stallEInt, stallMInt;
  logic             flushDInt, flushEInt, flushWInt;

  load_use_detect #(.WIDTH(WIDTH)) uLoadUse (
    .RegS1D   (RegS1D),
    .RegS2D   (RegS2D),
    .RegDestE (RegDestE),
    .MemReadE (MemReadE),
    .LoadUse  (loadUse)
  );

  assign memStall = ((state == HZ_RUN) && MemReqM && !MemReadyM) ||
                    ((state == HZ_WAIT) && !MemReadyM);

  always_comb begin
    stateNext = state;
    waitNext  = waitCnt;
    unique case (state)
      HZ_RUN: begin
        if (MemReqM && !MemReadyM) begin
          stateNext = HZ_WAIT;
          waitNext  = '0;
        end
      end
      HZ_WAIT: begin
        // Ready on the last allowed wait cycle still completes normally.
        if (MemReadyM) begin
          stateNext = HZ_RUN;
          waitNext  = '0;
        end else if (waitCnt == WAIT_LAST) begin
          stateNext = HZ_ERR;
        end else begin
          waitNext = waitCnt + 1'b1;
        end
      end
      HZ_ERR:  stateNext = HZ_ERR;
      default: stateNext = HZ_RUN;
    endcase
  end

  always_comb begin
    stallFInt = 1'b0;
    stallDInt = 1'b0;
    stallEInt = 1'b0;
    stallMInt = 1'b0;
    flushDInt = 1'b0;
    flushEInt = 1'b0;
    flushWInt = 1'b0;
    // Freezing for memory outranks everything; branch and load-use are seen again on resume.
    if (memStall || (state == HZ_ERR)) begin
      stallFInt = 1'b1;
      stallDInt = 1'b1;
      stallEInt = 1'b1;
      stallMInt = 1'b1;
      flushWInt = 1'b1;
    end else if (BranchTakenE) begin
      flushDInt = 1'b1;
      flushEInt = 1'b1;
    end else if (loadUse) begin
      stallFInt = 1'b1;
      stallDInt = 1'b1;
      flushEInt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HZ_RUN;
      waitCnt  <= '0;
      stallCnt <= '0;
      memErrQ  <= 1'b0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitNext;
      if (stallFInt && (stallCnt != {CNT_W{1'b1}})) begin
        stallCnt <= stallCnt + 1'b1;
      end
      if (stateNext == HZ_ERR) begin
        memErrQ <= 1'b1;
      end
    end
  end

  assign StallF     = !rst && stallFInt;
  assign StallD     = !rst && stallDInt;
  assign StallE     = !rst && stallEInt;
  assign StallM     = !rst && stallMInt;
  assign FlushD     = !rst && flushDInt;
  assign FlushE     = !rst && flushEInt;
  assign FlushW     = !rst && flushWInt;
  assign MemErr     = !rst && memErrQ;
  assign StallCount = rst ? '0 : stallCnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed scoreboard bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

  localparam int WIDTH    = 5;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] MEM  = 7'b1111001;
  localparam logic [6:0] LU   = 7'b1100010;
  localparam logic [6:0] BR   = 7'b0000110;

  typedef struct {
    string            tag;
    logic [6:0]       ctl;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] RegS1D, RegS2D, RegDestE;
  logic             MemReadE, BranchTakenE, MemReqM, MemReadyM;
  logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [CNT_W-1:0] StallCount;

  exp_t             sb[$];
  int               vectors = 0;
  int               miscompares = 0;
  logic             expErr = 1'b0;
  int               expCount = 0;

  hazard_stall_ctrl #(.WIDTH(WIDTH), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .RegS1D       (RegS1D),
    .RegS2D       (RegS2D),
    .RegDestE     (RegDestE),
    .MemReadE     (MemReadE),
    .BranchTakenE (BranchTakenE),
    .MemReqM      (MemReqM),
    .MemReadyM    (MemReadyM),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .StallM       (StallM),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushW       (FlushW),
    .MemErr       (MemErr),
    .StallCount   (StallCount)
  );

  always #5 clk = ~clk;

  task automatic step(input string tag, input logic r, input logic mr,
                      input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] s1,
                      input logic [WIDTH-1:0] s2, input logic br, input logic req,
                      input logic rdy, input logic [6:0] ctl);
    exp_t e;
    logic [6:0] obsCtl;
    @(posedge clk);
    #1;
    rst = r; MemReadE = mr; RegDestE = d; RegS1D = s1; RegS2D = s2;
    BranchTakenE = br; MemReqM = req; MemReadyM = rdy;
    e.tag = tag;
    e.ctl = r ? NONE : ctl;
    e.err = r ? 1'b0 : expErr;
    e.cnt = r ? '0 : CNT_W'(expCount);
    sb.push_back(e);
    #3;
    e = sb.pop_front();
    obsCtl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
    vectors++;
    assert (obsCtl === e.ctl) else begin
      miscompares++;
      $error("FAIL %s ctl observed=%b expected=%b", e.tag, obsCtl, e.ctl);
    end
    vectors++;
    assert (MemErr === e.err) else begin
      miscompares++;
      $error("FAIL %s MemErr observed=%b expected=%b", e.tag, MemErr, e.err);
    end
    vectors++;
    assert (StallCount === e.cnt) else begin
      miscompares++;
      $error("FAIL %s StallCount observed=%0d expected=%0d", e.tag, StallCount, e.cnt);
    end
    if (r) begin
      expCount = 0;
      expErr   = 1'b0;
    end else if (e.ctl[6] && expCount < (1 << CNT_W) - 1) begin
      expCount++;
    end
  endtask

  initial begin
    rst = 1'b1; MemReadE = 1'b0; RegDestE = '0; RegS1D = '0; RegS2D = '0;
    BranchTakenE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;

    step("reset",      1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NONE);
    step("idle",       0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NONE);
    step("lu_s1",      0, 1, 5'b01001, 5'b01001, 5'd2, 0, 0, 0, LU);
    step("lu_release", 0, 0, 5'b01001, 5'b01001, 5'd2, 0, 0, 0, NONE);
    step("reg0",       0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, NONE);
    step("lu_s2",      0, 1, 5'd3, 5'd7, 5'd3, 0, 0, 0, LU);
    step("no_match",   0, 1, 5'd3, 5'd7, 5'd8, 0, 0, 0, NONE);
    step("br_over_lu", 0, 1, 5'd3, 5'd3, 5'd0, 1, 0, 0, BR);
    step("br_only",    0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, BR);
    step("zero_wait",  0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, NONE);
    step("zw_after",   0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NONE);

    for (int i = 0; i < 3; i++) step("wait3", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, MEM);
    step("wait3_done", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, NONE);
    step("back_run",   0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NONE);

    step("prio_req",   0, 1, 5'd4, 5'd4, 5'd0, 1, 1, 0, MEM);
    step("prio_wait",  0, 1, 5'd4, 5'd4, 5'd0, 1, 0, 0, MEM);
    step("prio_ready", 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 1, BR);
    step("prio_run",   0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, BR);

    step("last_req",   0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, MEM);
    for (int i = 0; i < MAX_WAIT - 1; i++) step("last_wait", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, MEM);
    step("last_ready", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, NONE);
    step("last_run",   0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NONE);

    step("to_req",     0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, MEM);
    for (int i = 0; i < MAX_WAIT; i++) step("to_wait", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, MEM);
    expErr = 1'b1;
    for (int i = 0; i < 20; i++) step("err_hold", 0, 1, 5'd6, 5'd6, 5'd0, i[0], i[1], i[2], MEM);

    step("err_reset",  1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NONE);
    step("post_reset", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NONE);

    step("abort_req",  0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, MEM);
    step("abort_wait", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, MEM);
    step("abort_rst",  1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NONE);
    step("abort_run",  0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NONE);
    step("abort_br",   0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, BR);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
